pc_unit_ras: RTL and testbench
==============================

PC_UNIT_RAS -- requirements
Module: pc_unit_ras

Interface
REQ-001 Parameter WIDTH, 32, PC and target width in bits.
REQ-002 Parameter DEPTH, 4, return-address-stack (RAS) entries, power of two, 2..16.
REQ-003 Parameter STEP, 4, sequential increment added to PC.
REQ-004 Parameter RESET_VECTOR, 0, PC value after reset.
REQ-005 Parameter BREAK_VECTOR, 0, PC value loaded on break.
REQ-006 clock  input  1  clock; all state updates on rising edge.
REQ-007 Reset  input  1  synchronous, active-high reset.
REQ-008 stall  input  1  hold all state (nop/pipeline stall).
REQ-009 break_req  input  1  break request; load BREAK_VECTOR, enter HALT.
REQ-010 resume  input  1  leave HALT.
REQ-011 branch_en  input  1  load branch_target.
REQ-012 branch_target  input  WIDTH  branch/jump destination.
REQ-013 call_en  input  1  load branch_target and push return address.
REQ-014 ret_en  input  1  load PC from RAS top and pop.
REQ-015 pc_out  output  WIDTH  current PC, registered.
REQ-016 halted  output  1  high in HALT state, registered.
REQ-017 ras_count  output  $clog2(DEPTH)+1  valid RAS entries, 0..DEPTH.
REQ-018 ras_overflow  output  1  sticky: push occurred while full.
REQ-019 ras_underflow  output  1  sticky: pop occurred while empty.

Function
REQ-020 FSM states RUN and HALT; all outputs registered; every accepted event updates outputs on the same edge (1-cycle latency).
REQ-021 Per-edge priority: Reset > stall > break_req > (HALT: resume) > ret_en > call_en > branch_en > sequential.
REQ-022 stall=1: pc_out, FSM, RAS, count and flags unchanged, all other inputs ignored.
REQ-023 break_req=1 (either state): pc_out<=BREAK_VECTOR, state<=HALT, ras_count<=0; sticky flags retained.
REQ-024 HALT without break_req: pc_out held; resume=1 -> state RUN, pc_out unchanged that edge; ret/call/branch ignored.
REQ-025 RUN, sequential: pc_out<=pc_out+STEP, modulo 2^WIDTH (wraps, no flag).
REQ-026 branch_en: pc_out<=branch_target; RAS untouched.
REQ-027 call_en: pc_out<=branch_target; push (pc_out+STEP) mod 2^WIDTH; ras_count+1.
REQ-028 Push when ras_count==DEPTH: oldest entry overwritten (circular), ras_count stays DEPTH, ras_overflow<=1.
REQ-029 ret_en with ras_count>0: pc_out<=top entry, entry popped, ras_count-1.
REQ-030 ret_en with ras_count==0: pc_out<=pc_out+STEP, ras_underflow<=1, count stays 0.
REQ-031 ret_en with call_en and/or branch_en: return executes, others ignored, no push.
REQ-032 After overflow, pops return the newest DEPTH addresses in LIFO order; the DEPTH+1th pop underflows.

Reset
REQ-033 Reset=1 on an edge, regardless of other inputs or state: pc_out<=RESET_VECTOR, state<=RUN, halted<=0, ras_count<=0, ras_overflow<=0, ras_underflow<=0.
REQ-034 Reset mid-HALT or mid-stall takes effect the same edge; RAS contents need not be cleared, only ras_count.
REQ-035 Sticky flags clear only on Reset.

Verification (WIDTH=32, DEPTH=4, STEP=4, RESET_VECTOR=0x100, BREAK_VECTOR=0x80)
REQ-036 Reset 1 cycle then 3 idle cycles -> pc_out 0x100, 0x104, 0x108, 0x10C; halted=0, ras_count=0.
REQ-037 At pc 0x200 call_en target 0x400, 2 idle, ret_en -> pc 0x400, 0x404, 0x408, then 0x204; ras_count 1 then 0.
REQ-038 Five nested calls from pcs 0x10,0x20,0x30,0x40,0x50, then five rets -> ras_overflow=1 after 5th call; rets yield 0x54,0x44,0x34,0x24, 5th ret gives pc+4 and ras_underflow=1.
REQ-039 break_req with stall=1 -> no change; stall=0 break_req -> pc 0x80, halted=1, ras_count=0; 3 cycles hold 0x80; resume -> halted=0, next cycle 0x84.
REQ-040 pc_out=0xFFFFFFFC idle -> 0x00000000, no flag; ret_en+call_en same cycle with 1 entry 0x300 -> pc 0x300, ras_count 0.
REQ-041 Reset asserted while HALT with flags set -> pc 0x100, halted=0, both flags 0, ras_count=0.

Source files
------------

// File: rtl/pc_unit_ras.sv
// Program counter with break/halt control and a circular return-address stack.
// Priority per edge: Reset > stall > break_req > resume (HALT) > ret > call > branch > sequential.
module pc_unit_ras #(
    parameter int unsigned WIDTH              = 32,
    parameter int unsigned DEPTH              = 4,
    parameter int unsigned STEP               = 4,
    parameter logic [WIDTH-1:0] RESET_VECTOR  = '0,
    parameter logic [WIDTH-1:0] BREAK_VECTOR  = '0
) (
    input  logic                       clock,
    input  logic                       Reset,
    input  logic                       stall,
    input  logic                       break_req,
    input  logic                       resume,
    input  logic                       branch_en,
    input  logic [WIDTH-1:0]           branch_target,
    input  logic                       call_en,
    input  logic                       ret_en,
    output logic [WIDTH-1:0]           pc_out,
    output logic                       halted,
    output logic [$clog2(DEPTH):0]     ras_count,
    output logic                       ras_overflow,
    output logic                       ras_underflow
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef enum logic {S_RUN = 1'b0, S_HALT = 1'b1} state_t;

    state_t             state_q;
    logic [WIDTH-1:0]   pc_q;
    logic [WIDTH-1:0]   ras_q [DEPTH];
    logic [PW-1:0]      ptr_q;
    logic [CW-1:0]      count_q;
    logic               ovf_q;
    logic               unf_q;

    logic [WIDTH-1:0]   pc_seq_d;
    logic [PW-1:0]      top_idx_d;
    logic               ras_full_d;
    logic               ras_empty_d;

    // ptr_q is the next write slot; the newest entry sits just below it.
    assign pc_seq_d    = pc_q + WIDTH'(STEP);
    assign top_idx_d   = ptr_q - PW'(1);
    assign ras_full_d  = (count_q == CW'(DEPTH));
    assign ras_empty_d = (count_q == '0);

    always_ff @(posedge clock) begin
        if (Reset) begin
            state_q <= S_RUN;
            pc_q    <= RESET_VECTOR;
            ptr_q   <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else if (!stall) begin
            if (break_req) begin
                state_q <= S_HALT;
                pc_q    <= BREAK_VECTOR;
                count_q <= '0;
            end else begin
                case (state_q)
                    S_HALT: begin
                        if (resume) state_q <= S_RUN;
                    end
                    default: begin
                        if (ret_en) begin
                            if (ras_empty_d) begin
                                pc_q  <= pc_seq_d;
                                unf_q <= 1'b1;
                            end else begin
                                pc_q    <= ras_q[top_idx_d];
                                ptr_q   <= top_idx_d;
                                count_q <= count_q - CW'(1);
                            end
                        end else if (call_en) begin
                            // A full stack wraps onto its oldest entry.
                            ras_q[ptr_q] <= pc_seq_d;
                            ptr_q        <= ptr_q + PW'(1);
                            pc_q         <= branch_target;
                            if (ras_full_d) ovf_q   <= 1'b1;
                            else            count_q <= count_q + CW'(1);
                        end else if (branch_en) begin
                            pc_q <= branch_target;
                        end else begin
                            pc_q <= pc_seq_d;
                        end
                    end
                endcase
            end
        end
    end

    assign pc_out        = pc_q;
    assign halted        = (state_q == S_HALT);
    assign ras_count     = count_q;
    assign ras_overflow  = ovf_q;
    assign ras_underflow = unf_q;

endmodule

// File: tb/tb_pc_unit_ras.sv
// Bench for pc_unit_ras: directed scenarios then random traffic against a queue-based model.
module tb_pc_unit_ras;

    logic        clock = 1'b0;
    logic        Reset, stall, break_req, resume, branch_en, call_en, ret_en;
    logic [31:0] branch_target;
    logic [31:0] pc_out;
    logic        halted, ras_overflow, ras_underflow;
    logic [2:0]  ras_count;

    int tests = 0;
    int fails = 0;

    // Reference model state
    logic [31:0] m_pc;
    bit          m_halt, m_ovf, m_unf;
    logic [31:0] m_stack[$];

    pc_unit_ras #(
        .WIDTH(32), .DEPTH(4), .STEP(4),
        .RESET_VECTOR(32'h100), .BREAK_VECTOR(32'h80)
    ) dut (
        .clock(clock), .Reset(Reset), .stall(stall), .break_req(break_req),
        .resume(resume), .branch_en(branch_en), .branch_target(branch_target),
        .call_en(call_en), .ret_en(ret_en), .pc_out(pc_out), .halted(halted),
        .ras_count(ras_count), .ras_overflow(ras_overflow), .ras_underflow(ras_underflow)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        if (Reset) begin
            m_pc = 32'h100; m_halt = 0; m_ovf = 0; m_unf = 0; m_stack.delete();
        end else if (stall) begin
            // nothing changes
        end else if (break_req) begin
            m_pc = 32'h80; m_halt = 1; m_stack.delete();
        end else if (m_halt) begin
            if (resume) m_halt = 0;
        end else if (ret_en) begin
            if (m_stack.size() > 0) m_pc = m_stack.pop_back();
            else begin m_pc = m_pc + 32'd4; m_unf = 1; end
        end else if (call_en) begin
            m_stack.push_back(m_pc + 32'd4);
            if (m_stack.size() > 4) begin
                void'(m_stack.pop_front());
                m_ovf = 1;
            end
            m_pc = branch_target;
        end else if (branch_en) begin
            m_pc = branch_target;
        end else begin
            m_pc = m_pc + 32'd4;
        end
    endtask

    // Apply one cycle of inputs, advance model and DUT, then compare everything.
    task automatic cyc(input logic rst, input logic stl, input logic brk, input logic res,
                       input logic br, input logic cl, input logic rt, input logic [31:0] tgt);
        Reset = rst; stall = stl; break_req = brk; resume = res;
        branch_en = br; call_en = cl; ret_en = rt; branch_target = tgt;
        model_step();
        @(posedge clock);
        #1;
        chk("pc_out", pc_out, m_pc);
        chk("halted", {31'd0, halted}, {31'd0, m_halt});
        chk("ras_count", {29'd0, ras_count}, 32'(m_stack.size()));
        chk("ras_overflow", {31'd0, ras_overflow}, {31'd0, m_ovf});
        chk("ras_underflow", {31'd0, ras_underflow}, {31'd0, m_unf});
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, 0, 0, 0, 32'h0);
    endtask

    initial begin
        m_pc = 32'h0; m_halt = 0; m_ovf = 0; m_unf = 0;

        // Reset then sequential
        cyc(1, 0, 0, 0, 0, 0, 0, 32'h0);
        chk("rst_pc", pc_out, 32'h100);
        idle(); chk("seq1", pc_out, 32'h104);
        idle(); chk("seq2", pc_out, 32'h108);
        idle(); chk("seq3", pc_out, 32'h10C);
        chk("seq_cnt", {29'd0, ras_count}, 32'd0);

        // Call / return
        cyc(0, 0, 0, 0, 1, 0, 0, 32'h200);
        cyc(0, 0, 0, 0, 0, 1, 0, 32'h400);
        chk("call_pc", pc_out, 32'h400);
        chk("call_cnt", {29'd0, ras_count}, 32'd1);
        idle(); chk("call_seq1", pc_out, 32'h404);
        idle(); chk("call_seq2", pc_out, 32'h408);
        cyc(0, 0, 0, 0, 0, 0, 1, 32'h0);
        chk("ret_pc", pc_out, 32'h204);
        chk("ret_cnt", {29'd0, ras_count}, 32'd0);

        // Overflow by five nested calls, then five returns
        cyc(0, 0, 0, 0, 1, 0, 0, 32'h10);
        for (int i = 1; i <= 5; i++) cyc(0, 0, 0, 0, 0, 1, 0, 32'(16 * (i + 1)));
        chk("ovf_flag", {31'd0, ras_overflow}, 32'd1);
        chk("ovf_cnt", {29'd0, ras_count}, 32'd4);
        cyc(0, 0, 0, 0, 0, 0, 1, 32'h0); chk("pop1", pc_out, 32'h54);
        cyc(0, 0, 0, 0, 0, 0, 1, 32'h0); chk("pop2", pc_out, 32'h44);
        cyc(0, 0, 0, 0, 0, 0, 1, 32'h0); chk("pop3", pc_out, 32'h34);
        cyc(0, 0, 0, 0, 0, 0, 1, 32'h0); chk("pop4", pc_out, 32'h24);
        cyc(0, 0, 0, 0, 0, 0, 1, 32'h0); chk("pop5_pc", pc_out, 32'h28);
        chk("unf_flag", {31'd0, ras_underflow}, 32'd1);

        // Break under stall, break, halt hold, resume
        cyc(0, 1, 1, 0, 0, 0, 0, 32'h0);
        chk("stall_brk_pc", pc_out, 32'h28);
        chk("stall_brk_halt", {31'd0, halted}, 32'd0);
        cyc(0, 0, 0, 0, 0, 1, 0, 32'h900);
        cyc(0, 0, 1, 0, 0, 0, 0, 32'h0);
        chk("brk_pc", pc_out, 32'h80);
        chk("brk_halt", {31'd0, halted}, 32'd1);
        chk("brk_cnt", {29'd0, ras_count}, 32'd0);
        cyc(0, 0, 0, 0, 0, 0, 1, 32'h0);
        cyc(0, 0, 0, 0, 0, 1, 0, 32'h600);
        cyc(0, 0, 0, 0, 1, 0, 0, 32'h700);
        chk("halt_hold", pc_out, 32'h80);
        cyc(0, 0, 0, 1, 0, 0, 0, 32'h0);
        chk("resume_pc", pc_out, 32'h80);
        chk("resume_halt", {31'd0, halted}, 32'd0);
        idle(); chk("resume_next", pc_out, 32'h84);

        // Wrap and ret+call collision
        cyc(0, 0, 0, 0, 1, 0, 0, 32'hFFFF_FFFC);
        idle(); chk("wrap_pc", pc_out, 32'h0);
        cyc(0, 0, 0, 0, 1, 0, 0, 32'h2FC);
        cyc(0, 0, 0, 0, 0, 1, 0, 32'h500);
        cyc(0, 0, 0, 0, 1, 1, 1, 32'h700);
        chk("retcall_pc", pc_out, 32'h300);
        chk("retcall_cnt", {29'd0, ras_count}, 32'd0);

        // Reset in HALT with flags set, and reset under stall
        cyc(0, 0, 1, 0, 0, 0, 0, 32'h0);
        cyc(1, 1, 1, 1, 1, 1, 1, 32'h123);
        chk("rst_halt_pc", pc_out, 32'h100);
        chk("rst_halt_h", {31'd0, halted}, 32'd0);
        chk("rst_ovf", {31'd0, ras_overflow}, 32'd0);
        chk("rst_unf", {31'd0, ras_underflow}, 32'd0);

        // Random traffic
        for (int n = 0; n < 600; n++) begin
            logic [31:0] t;
            t = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 3) * 4))
                                            : ($urandom & 32'hFFFF_FFFC);
            cyc(($urandom_range(0, 60) == 0), ($urandom_range(0, 9) == 0),
                ($urandom_range(0, 25) == 0), ($urandom_range(0, 2) == 0),
                ($urandom_range(0, 4) == 0), ($urandom_range(0, 2) == 0),
                ($urandom_range(0, 3) == 0), t);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
